// File: rtl/lstm_input_sequencer.sv
// lstm_input_sequencer: I/Q sample FIFO feeding one timestep at a time to the LSTM cell, with frame counting.
module lstm_input_sequencer #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 8,
  parameter int SEQ_LEN = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_i,
  input  logic [DATA_W-1:0]          in_q,
  output logic                       in_ready,
  input  logic                       hidden_done,
  output logic [DATA_W-1:0]          x_i,
  output logic [DATA_W-1:0]          x_q,
  output logic                       enable_input,
  output logic [$clog2(SEQ_LEN)-1:0] step_cnt,
  output logic                       frame_done,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(SEQ_LEN);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem_i [DEPTH];
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop, has_data, step_last;
  assign has_data  = count != '0;
  assign in_ready  = !rst && (count != CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign step_last = step_cnt == SW'(SEQ_LEN - 1);
  always_comb begin
    pop      = (state == S_RUN) ? hidden_done && has_data : has_data;
    state_nx = (state == S_RUN && hidden_done && !has_data) ? S_WAIT :
               (state != S_RUN && has_data) ? S_RUN : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_i[wr_ptr] <= in_i;
      mem_q[wr_ptr] <= in_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      x_i          <= '0;
      x_q          <= '0;
      enable_input <= 1'b0;
      step_cnt     <= '0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr + AW'(push);
      rd_ptr       <= rd_ptr + AW'(pop);
      count        <= count + CW'(push) - CW'(pop);
      enable_input <= state_nx == S_RUN;
      frame_done   <= state == S_RUN && hidden_done && step_last;
      overflow     <= overflow || (in_valid && !in_ready);
      if (pop) begin
        x_i <= mem_i[rd_ptr];
        x_q <= mem_q[rd_ptr];
      end
      // WAIT keeps the step index so a starved frame resumes where it left off
      if (state == S_IDLE) step_cnt <= '0;
      else if (state == S_RUN && hidden_done) step_cnt <= step_last ? '0 : step_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_lstm_input_sequencer.sv
// tb_lstm_input_sequencer: directed and randomized checks against a queue-based timestep model.
module tb_lstm_input_sequencer;
  localparam int DW = 16;
  localparam int D  = 4;
  localparam int SL = 4;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, hidden_done = 1'b0;
  logic [DW-1:0] in_i = '0, in_q = '0;
  logic in_ready, enable_input, frame_done, overflow;
  logic [DW-1:0] x_i, x_q;
  logic [$clog2(SL)-1:0] step_cnt;
  int tests = 0, fails = 0;
  logic [31:0] q_m [$];
  int m_step = 0;
  bit m_en = 0, m_started = 0, m_fd = 0, m_ovf = 0;
  logic [DW-1:0] m_xi = '0, m_xq = '0;

  lstm_input_sequencer #(.DATA_W(DW), .DEPTH(D), .SEQ_LEN(SL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_i(in_i), .in_q(in_q), .in_ready(in_ready),
    .hidden_done(hidden_done), .x_i(x_i), .x_q(x_q), .enable_input(enable_input),
    .step_cnt(step_cnt), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit v, input logic [DW-1:0] i, input logic [DW-1:0] q, input bit hd);
    bit ready, avail;
    logic [31:0] e;
    in_valid = v; in_i = i; in_q = q; hidden_done = hd;
    @(posedge clk);
    if (rst) begin
      q_m.delete(); m_en = 0; m_started = 0; m_fd = 0; m_ovf = 0; m_xi = '0; m_xq = '0; m_step = 0;
    end else begin
      ready = q_m.size() < D;
      avail = q_m.size() > 0;
      if (in_valid && !ready) m_ovf = 1;
      m_fd = 0;
      if (m_en && hidden_done) begin
        m_fd = (m_step == SL - 1);
        m_step = (m_step + 1) % SL;
      end
      if ((!m_en || hidden_done) && avail) begin
        e = q_m.pop_front();
        {m_xi, m_xq} = e;
        if (!m_started) m_step = 0;
        m_started = 1;
        m_en = 1;
      end else if (m_en && hidden_done) m_en = 0;
      if (in_valid && ready) q_m.push_back({in_i, in_q});
    end
    #1;
    chk("x_i", 32'(x_i), 32'(m_xi));
    chk("x_q", 32'(x_q), 32'(m_xq));
    chk("enable_input", 32'(enable_input), 32'(m_en));
    chk("step_cnt", 32'(step_cnt), 32'(m_step));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("in_ready", 32'(in_ready), 32'(!rst && q_m.size() < D));
  endtask

  initial begin
    int pv;
    rst = 1;
    repeat (3) step(1, 16'h5555, 16'haaaa, 0);
    rst = 0;
    #1 chk("ready_after_rst", 32'(in_ready), 32'd1);
    step(1, 16'h0123, 16'hfedc, 0);
    step(0, 16'h0, 16'h0, 0);
    chk("single_en", 32'(enable_input), 32'd1);
    chk("single_xi", 32'(x_i), 32'h0123);
    chk("single_xq", 32'(x_q), 32'hfedc);
    step(0, 16'h0, 16'h0, 1);
    chk("single_wait_en", 32'(enable_input), 32'd0);
    chk("single_wait_step", 32'(step_cnt), 32'd1);
    rst = 1; step(0, 16'h0, 16'h0, 0); rst = 0;
    for (int k = 1; k <= 4; k++) step(1, 16'(k), 16'(~k), 0);
    for (int t = 0; t < 4; t++) begin
      step(t == 3, 16'h0005, 16'h0050, 0);
      step(0, 16'h0, 16'h0, 0);
      step(0, 16'h0, 16'h0, 0);
      chk("frame_en", 32'(enable_input), 32'd1);
      chk("frame_xi", 32'(x_i), 32'(t + 1));
      step(0, 16'h0, 16'h0, 1);
    end
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    chk("frame_step0", 32'(step_cnt), 32'd0);
    chk("frame_xi5", 32'(x_i), 32'h0005);
    step(0, 16'h0, 16'h0, 0);
    chk("frame_done_drop", 32'(frame_done), 32'd0);
    rst = 1; step(0, 16'h0, 16'h0, 0); rst = 0;
    for (int k = 0; k < 6; k++) step(1, 16'(16'h10 + k), 16'h0, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_ready", 32'(in_ready), 32'd0);
    step(0, 16'h0, 16'h0, 0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) pv = int'($urandom_range(1, 9));
      rst = ($urandom_range(99) == 0);
      step(int'($urandom_range(9)) < pv, 16'($urandom), 16'($urandom), $urandom_range(3) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
